// File: rtl/mac_unit.sv
// Sequential signed 8x8 multiply-accumulate: an 8-step radix-2 Booth multiplier
// feeding a 32-bit wrapping accumulator, with a valid/done handshake.
module mac_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [31:0] y,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  mcand;
  logic [8:0]  hi;
  logic [7:0]  lo;
  logic        qm1;
  logic [2:0]  cnt;
  logic [8:0]  sum;
  logic [8:0]  mcand_ext;
  logic [15:0] product;

  // The upper half carries a guard bit so that subtracting -128 cannot overflow.
  assign mcand_ext = {mcand[7], mcand};
  assign product   = {hi[7:0], lo};

  always_comb begin
    sum = hi;
    case ({lo[0], qm1})
      2'b01:   sum = hi + mcand_ext;
      2'b10:   sum = hi - mcand_ext;
      default: sum = hi;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      y     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            mcand <= A;
            hi    <= '0;
            lo    <= B;
            qm1   <= 1'b0;
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          hi  <= {sum[8], sum[8:1]};
          lo  <= {sum[0], lo[7:1]};
          qm1 <= lo[0];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= ACC;
        end
        ACC: begin
          y     <= y + {{16{product[15]}}, product};
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// Directed and randomized self-checking bench for mac_unit; inputs driven and
// outputs sampled on the falling clock edge.
module tb_mac_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [31:0] y;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  mac_unit dut (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .A     (A),
    .B     (B),
    .y     (y),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulse valid for one cycle, scramble operands afterwards, wait for done.
  task automatic run_pair(input logic [7:0] a, input logic [7:0] b, output int lat);
    bit found;
    A = a;
    B = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    lat = 1;
    found = 0;
    while (!found && lat < 30) begin
      if (done) found = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0]  seq_a [7] = '{8'd5, 8'd4, -8'sd6, 8'd7, -8'sd3, 8'd2, -8'sd1};
  logic [7:0]  seq_b [7] = '{8'd3, -8'sd2, 8'd1, 8'd2, -8'sd4, 8'd6, 8'd5};
  logic [31:0] seq_y [7] = '{32'd15, 32'd7, 32'd1, 32'd15, 32'd27, 32'd39, 32'd34};

  initial begin
    int lat;
    int ndone;
    int last;
    logic [31:0] ref_y;
    logic [7:0]  ra, rb;

    reset = 1'b1;
    valid = 1'b0;
    A = '0;
    B = '0;
    #12;
    check("reset_y", y, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Accumulation sequence; first pair also checks latency and pulse width.
    for (int i = 0; i < 7; i++) begin
      run_pair(seq_a[i], seq_b[i], lat);
      check($sformatf("seq_y%0d", i), y, seq_y[i]);
      if (i == 0) check("latency", 32'(lat), 32'd10);
      @(negedge clk);
      if (i == 0) check("done_width", {31'd0, done}, 32'd0);
    end

    // Asynchronous reset between edges clears outputs immediately.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_y", y, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset during MUL aborts without touching y.
    A = 8'd50;
    B = 8'd50;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mul_abort_done", 32'(ndone), 32'd0);
    check("mul_abort_y", y, 32'd0);

    // Corner products from reset.
    do_reset();
    run_pair(8'h80, 8'h80, lat);
    check("corner_m128_m128", y, 32'd16384);
    @(negedge clk);
    run_pair(8'h80, 8'h7f, lat);
    check("corner_m128_127", y, 32'd128);
    @(negedge clk);
    run_pair(8'd0, -8'sd77, lat);
    check("corner_0_m77", y, 32'd128);
    @(negedge clk);

    // Extra valid pulses in MUL and ACC are ignored.
    A = 8'd10;
    B = 8'd10;
    valid = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      valid = (n == 3 || n == 9);
      A = (n == 3 || n == 9) ? 8'd100 : 8'd0;
      B = (n == 3 || n == 9) ? 8'd100 : 8'd0;
      if (done) ndone++;
    end
    check("ignored_valid_dones", 32'(ndone), 32'd1);
    check("ignored_valid_y", y, 32'd228);

    // Back-to-back with valid held high.
    do_reset();
    A = 8'd1;
    B = 8'd1;
    valid = 1'b1;
    ndone = 0;
    last = 0;
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check($sformatf("b2b_y%0d", ndone), y, 32'(ndone));
        check($sformatf("b2b_period%0d", ndone), 32'(n - last), 32'd10);
        last = n;
      end
    end
    check("b2b_count", 32'(ndone), 32'd3);
    valid = 1'b0;

    // Randomized pairs against a wrapping reference.
    do_reset();
    ref_y = '0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i == 0) begin ra = 8'h80; rb = 8'h80; end
      if (i == 1) begin ra = 8'h7f; rb = 8'h80; end
      ref_y = ref_y + 32'($signed(ra) * $signed(rb));
      run_pair(ra, rb, lat);
      check($sformatf("rand%0d", i), y, ref_y);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_unit.md
# mac_unit

Sequential signed multiply-accumulate unit. Each accepted operand pair A×B (signed 8-bit) is multiplied by an iterative 8-step radix-2 Booth multiplier, and the product is added into a 32-bit signed accumulator `y`. A one-cycle `done` pulse marks each accumulator update. The unit is the per-cell arithmetic element of the systolic MAC array and is driven by a simple valid/done handshake.

## Interface
- No parameters; widths are fixed (8-bit operands, 16-bit product, 32-bit accumulator).
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-high.
- `valid` input 1: request; sampled only in IDLE.
- `A` input 8: signed multiplicand, two's complement.
- `B` input 8: signed multiplier, two's complement.
- `y` output 32: signed accumulator, registered.
- `done` output 1: registered one-cycle pulse, high in the cycle after `y` is updated.

## Operation
- The FSM has three states: IDLE, MUL and ACC.
- IDLE:
  - If `valid`=1 at a rising edge, latch A and B, clear the product register and the 3-bit step counter, then go to MUL.
  - Otherwise stay in IDLE.
- MUL:
  - One Booth step per cycle, for exactly 8 cycles.
  - After the 8th step, go to ACC.
  - Operands are held internally, so A and B may change after the capture edge.
- ACC:
  - `y <= y + sign_extend32(product16)`.
  - `done <= 1`.
  - Next state is IDLE.
- In every other cycle, `done` is registered low.
- Product must be the exact signed 16-bit result for all 65536 operand pairs, including -128×-128 = +16384 and -128×127 = -16256.
- Accumulation is modulo 2^32 with two's-complement wrap. There is no saturation and no overflow flag.
- `valid` asserted in MUL or ACC is ignored. It is not queued.
- `y` holds its value in all states except ACC. It is never cleared except by `reset`.
- Reset:
  - Asynchronous; `y`=0, `done`=0, state IDLE, internal registers 0.
  - Reset mid-operation aborts the operation with no partial update of `y`.
  - The first edge after deassertion with `valid`=1 starts a new operation.

## Timing
- Latency: `valid` sampled at edge E0, then MUL on edges E1..E8, then ACC at edge E9.
- At E9 `y` takes its new value and `done` goes to 1. `done` returns to 0 at E10.
- Earliest next capture is E10, so the initiation interval is 10 cycles.
- A `valid` level held across E10 is accepted at E10.
- Both `y` and `done` are stable for a full cycle after changing. A bench may sample `y` at the edge after `done` rises.
- `valid` may be a one-cycle pulse or held longer. Holding it through the operation does not start a second operation until the unit is back in IDLE.

## Test plan
- Reset:
  - Assert `reset` asynchronously mid-cycle: `y`=0 and `done`=0 immediately.
  - Assert `reset` during MUL step 4: no `done`, and `y` stays 0.
- Accumulation sequence, `valid` pulsed once per pair and waiting for `done` each time:
  - Pairs: (5,3), (4,-2), (-6,1), (7,2), (-3,-4), (2,6), (-1,5).
  - Required `y` after each `done`: 15, 7, 1, 15, 27, 39, 34.
- Corner products from reset:
  - (-128,-128): `y` = 16384.
  - Then (-128,127): `y` = 128.
  - Then (0,-77): `y` = 128.
- Latency and handshake:
  - `done` rises exactly 9 edges after the capture edge and is high for exactly 1 cycle.
  - A second `valid` pulse during MUL or ACC is ignored: only one `done`, one product added.
- Back-to-back:
  - Hold `valid`=1 continuously with A=1, B=1.
  - `done` pulses every 10 cycles and `y` increments by 1 per pulse.
- Randomized: 1000 random pairs against a 32-bit wrapping signed reference model, with `y` compared at every `done`.
